// File: rtl/pipe_if_ifid.sv
// rtl/pipe_if_ifid.sv - instruction-fetch stage producing the 64-bit IFID bundle {Instruct, PC}
// Optional fetch/bubble counters are built when PIPE_IF_PERF_EN is defined.
module pipe_if_ifid #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stallin,
  input  logic [2:0]  PCSrc,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  input  logic        BranchTaken,
  input  logic [31:0] ConBA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [63:0] IFID,
  output logic        FetchBusy
`ifdef PIPE_IF_PERF_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] BubbleCnt
`endif
);

  localparam logic [2:0] PCSRC_J     = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_IRQ   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] skid_q, skid_d;
  logic [63:0] ifid_q, ifid_d;
  logic        req_q, req_d;

  logic [31:0] pc_inc;
  logic [31:0] id_target;
  logic [31:0] target;
  logic        id_redir;
  logic        redirect;
  logic        deliver_fetch;
  logic        deliver_skid;
  logic        write_bubble;

  // Sequential step keeps the supervisor bit and wraps the low 31 bits.
  assign pc_inc = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    id_target = pc_inc;
    case (PCSrc)
      PCSRC_J:     id_target = {pc_q[31:28], JT, 2'b00};
      PCSRC_JR:    id_target = DataBusA;
      PCSRC_ILLOP: id_target = ILLOP_PC;
      PCSRC_IRQ:   id_target = XADR_PC;
      default:     id_target = pc_inc;
    endcase
    id_redir = !Stallin && (PCSrc >= PCSRC_J) && (PCSrc <= PCSRC_IRQ);
    redirect = (state_q != S_IDLE) && (BranchTaken || id_redir);
    target   = BranchTaken ? ConBA : id_target;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    ifid_d        = ifid_q;
    deliver_fetch = 1'b0;
    deliver_skid  = 1'b0;
    write_bubble  = 1'b0;

    if (redirect) begin
      // An unanswered request must still be completed, so it is drained in DROP.
      pc_d         = target;
      write_bubble = 1'b1;
      if ((state_q == S_FETCH || state_q == S_DROP) && !imem_valid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_FETCH;
          write_bubble = !Stallin;
        end
        S_FETCH: begin
          if (imem_valid) begin
            if (Stallin) begin
              skid_d  = imem_rdata;
              state_d = S_HOLD;
            end else begin
              deliver_fetch = 1'b1;
            end
          end else begin
            write_bubble = !Stallin;
          end
        end
        S_DROP: begin
          if (imem_valid) begin
            state_d = S_FETCH;
          end
          write_bubble = !Stallin;
        end
        S_HOLD: begin
          if (!Stallin) begin
            deliver_skid = 1'b1;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (deliver_fetch || deliver_skid) begin
      pc_d = pc_inc;
    end
    if (deliver_fetch) begin
      ifid_d = {imem_rdata, pc_q};
    end else if (deliver_skid) begin
      ifid_d = {skid_q, pc_q};
    end else if (write_bubble) begin
      ifid_d = {32'h0, pc_q};
    end

    req_d  = (state_d == S_FETCH) || (state_d == S_DROP);
    // While draining, the bus keeps the address of the transaction being completed.
    addr_d = (state_d == S_DROP) ? addr_q : {1'b0, pc_d[30:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= {1'b0, RESET_PC[30:0]};
      skid_q  <= 32'h0;
      ifid_q  <= 64'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      skid_q  <= skid_d;
      ifid_q  <= ifid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign IFID      = ifid_q;
  assign FetchBusy = req_q && !imem_valid;

`ifdef PIPE_IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (deliver_fetch || deliver_skid) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else if (write_bubble) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_if_ifid.sv
// tb/tb_pipe_if_ifid.sv - randomized self-checking bench for pipe_if_ifid
// Counter ports are connected and checked when PIPE_IF_PERF_EN is defined.
`timescale 1ns/1ps
module tb_pipe_if_ifid;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;
  localparam logic [31:0] LOW31    = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stallin = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic [25:0] JT = 26'h0;
  logic [31:0] DataBusA = 32'h0;
  logic        BranchTaken = 1'b0;
  logic [31:0] ConBA = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic [63:0] IFID;
  logic        FetchBusy;
`ifdef PIPE_IF_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model: PC, bundle, and whether a word is parked or a request is being thrown away.
  logic [31:0] m_pc;
  logic [31:0] m_skid;
  logic [63:0] m_ifid;
  bit          m_started, m_held, m_discard;
  int unsigned m_fetch, m_bubble;

  // Memory responder: mem_delay < 0 picks a random latency per request.
  bit mem_active;
  int mem_cnt;
  int mem_delay;

  pipe_if_ifid dut (
    .clk(clk), .reset(reset), .Stallin(Stallin), .PCSrc(PCSrc), .JT(JT),
    .DataBusA(DataBusA), .BranchTaken(BranchTaken), .ConBA(ConBA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .IFID(IFID), .FetchBusy(FetchBusy)
`ifdef PIPE_IF_PERF_EN
    , .FetchCnt(fetch_cnt), .BubbleCnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & LOW31);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_skid = 32'h0; m_ifid = 64'h0;
    m_started = 0; m_held = 0; m_discard = 0;
    m_fetch = 0; m_bubble = 0;
    mem_active = 0; mem_cnt = 0; imem_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_ifid = {32'h0, m_pc};
    m_bubble++;
  endtask

  task automatic model_step();
    bit req_now;
    bit id_redir;
    logic [31:0] tgt;
    req_now  = m_started && !m_held;
    id_redir = !Stallin && PCSrc >= 3'd2 && PCSrc <= 3'd5;
    if (!m_started) begin
      m_started = 1;
      if (!Stallin) model_bubble();
    end else if (BranchTaken || id_redir) begin
      if (BranchTaken) tgt = ConBA;
      else if (PCSrc == 3'd4) tgt = ILLOP_PC;
      else if (PCSrc == 3'd5) tgt = XADR_PC;
      else if (PCSrc == 3'd2) tgt = (m_pc & 32'hF000_0000) | ({6'h0, JT} * 32'd4);
      else tgt = DataBusA;
      model_bubble();
      m_discard = req_now && !imem_valid;
      m_held = 0;
      m_pc = tgt;
    end else if (m_discard) begin
      if (imem_valid) m_discard = 0;
      if (!Stallin) model_bubble();
    end else if (m_held) begin
      if (!Stallin) begin
        m_ifid = {m_skid, m_pc}; m_pc = seq_next(m_pc); m_held = 0; m_fetch++;
      end
    end else if (imem_valid) begin
      if (Stallin) begin
        m_held = 1; m_skid = imem_rdata;
      end else begin
        m_ifid = {imem_rdata, m_pc}; m_pc = seq_next(m_pc); m_fetch++;
      end
    end else if (!Stallin) begin
      model_bubble();
    end
  endtask

  task automatic mem_drive();
    if (imem_req && reset) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      imem_valid = (mem_cnt == 0);
    end else begin
      imem_valid = 1'b0;
    end
    imem_rdata = $urandom | 32'h1;
  endtask

  task automatic set_in(input bit st, input logic [2:0] ps, input logic [25:0] jt,
                        input logic [31:0] dba, input bit bt, input logic [31:0] cba);
    Stallin = st; PCSrc = ps; JT = jt; DataBusA = dba; BranchTaken = bt; ConBA = cba;
    mem_drive();
    #1;
  endtask

  task automatic idle();
    set_in(0, 3'd0, 26'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (mem_active) begin
      if (imem_valid) mem_active = 0;
      else mem_cnt--;
    end
    #2;
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    n_checks++; if (IFID !== 64'h0) begin n_fail++; $display("FAIL rst_ifid: got %h want %h", IFID, 64'h0); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (FetchBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", FetchBusy); end
    @(posedge clk); #2;
    n_checks++; if (IFID !== 64'h0) begin n_fail++; $display("FAIL rst_hold_ifid: got %h want %h", IFID, 64'h0); end
    reset = 1'b1;
    idle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (IFID !== {32'h0, RESET_PC}) begin n_fail++; $display("FAIL idle_bubble: got %h want %h", IFID, {32'h0, RESET_PC}); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    mem_delay = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      w = imem_rdata;
      n_checks++; if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_addr%0d: got %h want %h", i, imem_addr, 32'(i * 4)); end
      n_checks++; if (FetchBusy !== 1'b0) begin n_fail++; $display("FAIL zw_busy%0d: got %b want 0", i, FetchBusy); end
      tick();
      n_checks++; if (IFID !== {w, RESET_PC + 32'(i * 4)}) begin n_fail++; $display("FAIL zw_ifid%0d: got %h want %h", i, IFID, {w, RESET_PC + 32'(i * 4)}); end
    end
  endtask

  task automatic test_fetch_wait();
    logic [31:0] w;
    mem_delay = 3;
    for (int i = 0; i < 4; i++) begin
      idle();
      w = imem_rdata;
      n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL wait_addr%0d: got %h want %h", i, imem_addr, 32'hC); end
      n_checks++; if (FetchBusy !== (i < 3)) begin n_fail++; $display("FAIL wait_busy%0d: got %b want %b", i, FetchBusy, (i < 3)); end
      tick();
      if (i < 3) begin
        n_checks++; if (IFID !== {32'h0, 32'h8000_000C}) begin n_fail++; $display("FAIL wait_bubble%0d: got %h want %h", i, IFID, {32'h0, 32'h8000_000C}); end
      end else begin
        n_checks++; if (IFID !== {w, 32'h8000_000C}) begin n_fail++; $display("FAIL wait_word: got %h want %h", IFID, {w, 32'h8000_000C}); end
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] w;
    mem_delay = 0;
    set_in(0, 3'd2, 26'h10, 32'h0, 0, 32'h0);
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL jmp_src_addr: got %h want %h", imem_addr, 32'h10); end
    tick();
    n_checks++; if (IFID !== {32'h0, 32'h8000_0010}) begin n_fail++; $display("FAIL jmp_bubble: got %h want %h", IFID, {32'h0, 32'h8000_0010}); end
    idle();
    w = imem_rdata;
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL jmp_addr: got %h want %h", imem_addr, 32'h40); end
    tick();
    n_checks++; if (IFID !== {w, 32'h8000_0040}) begin n_fail++; $display("FAIL jmp_ifid: got %h want %h", IFID, {w, 32'h8000_0040}); end
  endtask

  task automatic test_branch_drop();
    logic [31:0] w;
    mem_delay = 2;
    set_in(0, 3'd0, 26'h0, 32'h0, 1, 32'h0000_0100);
    n_checks++; if (imem_addr !== 32'h44) begin n_fail++; $display("FAIL br_src_addr: got %h want %h", imem_addr, 32'h44); end
    tick();
    n_checks++; if (IFID !== {32'h0, 32'h8000_0044}) begin n_fail++; $display("FAIL br_bubble: got %h want %h", IFID, {32'h0, 32'h8000_0044}); end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_req%0d: got %b want 1", i, imem_req); end
      tick();
      n_checks++; if (IFID !== {32'h0, 32'h0000_0100}) begin n_fail++; $display("FAIL drop_ifid%0d: got %h want %h", i, IFID, {32'h0, 32'h0000_0100}); end
    end
    mem_delay = 0;
    idle();
    w = imem_rdata;
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr: got %h want %h", imem_addr, 32'h100); end
    tick();
    n_checks++; if (IFID !== {w, 32'h0000_0100}) begin n_fail++; $display("FAIL br_ifid: got %h want %h", IFID, {w, 32'h0000_0100}); end
  endtask

  task automatic test_stall_hold();
    logic [31:0] w;
    logic [63:0] held;
    mem_delay = 0;
    held = m_ifid;
    set_in(1, 3'd0, 26'h0, 32'h0, 0, 32'h0);
    w = imem_rdata;
    n_checks++; if (imem_valid !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL hold_fetch: got addr %h want %h", imem_addr, 32'h104); end
    tick();
    n_checks++; if (IFID !== held) begin n_fail++; $display("FAIL hold_ifid0: got %h want %h", IFID, held); end
    set_in(1, 3'd5, 26'h0, 32'h0, 0, 32'h0);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (IFID !== held) begin n_fail++; $display("FAIL hold_ifid1: got %h want %h", IFID, held); end
    idle();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req2: got %b want 0", imem_req); end
    tick();
    n_checks++; if (IFID !== {w, 32'h0000_0104}) begin n_fail++; $display("FAIL hold_release: got %h want %h", IFID, {w, 32'h0000_0104}); end
    idle();
    n_checks++; if (imem_addr !== 32'h108) begin n_fail++; $display("FAIL hold_next_addr: got %h want %h", imem_addr, 32'h108); end
    tick();
  endtask

  task automatic test_targets();
    logic [2:0]  ps;
    logic [31:0] dba, cba, e, w;
    bit          bt;
    mem_delay = 0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin ps = 3'd4; dba = 32'h0;         bt = 0; cba = 32'h0;   end
        1: begin ps = 3'd5; dba = 32'h0;         bt = 0; cba = 32'h0;   end
        2: begin ps = 3'd3; dba = 32'hFFFF_FFFC; bt = 0; cba = 32'h0;   end
        default: begin ps = 3'd4; dba = 32'h0;   bt = 1; cba = 32'h200; end
      endcase
      set_in(0, ps, 26'h0, dba, bt, cba);
      tick();
      n_checks++; if (IFID[63:32] !== 32'h0) begin n_fail++; $display("FAIL tgt%0d_bubble: got %h want 0", k, IFID[63:32]); end
      for (int j = 0; j < 2; j++) begin
        case (k)
          0: e = (j == 0) ? 32'h8000_0004 : 32'h8000_0008;
          1: e = (j == 0) ? 32'h8000_0008 : 32'h8000_000C;
          2: e = (j == 0) ? 32'hFFFF_FFFC : 32'h8000_0000;
          default: e = (j == 0) ? 32'h0000_0200 : 32'h0000_0204;
        endcase
        idle();
        w = imem_rdata;
        n_checks++; if (imem_addr !== (e & LOW31)) begin n_fail++; $display("FAIL tgt%0d_addr%0d: got %h want %h", k, j, imem_addr, e & LOW31); end
        tick();
        n_checks++; if (IFID !== {w, e}) begin n_fail++; $display("FAIL tgt%0d_ifid%0d: got %h want %h", k, j, IFID, {w, e}); end
      end
    end
  endtask

  task automatic test_reset_midwait();
    mem_delay = 3;
    idle();
    tick();
    idle();
    reset = 1'b0;
    #1;
    n_checks++; if (IFID !== 64'h0) begin n_fail++; $display("FAIL midrst_ifid: got %h want 0", IFID); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    model_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    mem_delay = 0;
    idle();
    tick();
    idle();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_restart: got req %b addr %h want 1 %h", imem_req, imem_addr, 32'h0); end
    tick();
    n_checks++; if (IFID[31:0] !== RESET_PC) begin n_fail++; $display("FAIL midrst_pc: got %h want %h", IFID[31:0], RESET_PC); end
  endtask

  task automatic test_random();
    logic [2:0] ps;
    bit exp_req;
    mem_delay = -1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ps = 3'($urandom_range(2, 5));
      else ps = (3'($urandom_range(0, 1)) == 3'd0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(6, 7));
      set_in($urandom_range(0, 3) == 0, ps, 26'($urandom), $urandom, $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC);
      exp_req = m_started && !m_held;
      n_checks++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc %0d: got %b want %b", i, imem_req, exp_req); end
      n_checks++; if (FetchBusy !== (exp_req && !imem_valid)) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b want %b", i, FetchBusy, exp_req && !imem_valid); end
      if (exp_req && !m_discard) begin
        n_checks++; if (imem_addr !== (m_pc & LOW31)) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", i, imem_addr, m_pc & LOW31); end
      end
      tick();
      n_checks++; if (IFID !== m_ifid) begin n_fail++; $display("FAIL rnd_ifid cyc %0d: got %h want %h", i, IFID, m_ifid); end
    end
`ifdef PIPE_IF_PERF_EN
    n_checks++; if (fetch_cnt !== 32'(m_fetch)) begin n_fail++; $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, m_fetch); end
    n_checks++; if (bubble_cnt !== 32'(m_bubble)) begin n_fail++; $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt, m_bubble); end
`endif
  endtask

  initial begin
    mem_delay = 0;
    model_reset();
    #12;
    test_reset();
    test_zero_wait();
    test_fetch_wait();
    test_jump();
    test_branch_drop();
    test_stall_hold();
    test_targets();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
